// File: rtl/point_double_seq.sv
// point_double_seq: sequential projective point doubling for twisted Edwards
// curves a*x^2 + y^2 = 1 + d*x^2*y^2 over GF(P), with a = +1 or -1.
// One bit-serial MSB-first modular multiplier is time-shared across the seven
// field products; modular add/sub runs in the ALU cycle that follows each
// product, and that ALU cycle also loads the multiplier operands for the next
// product.
//
// Optional feature: define POINT_DOUBLE_RANGE_CHECK_EN to flag inputs >= P
// (out_err = 1, zero result, short path). Without it out_err is tied low.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    input handshake; x1, y1, z1 sampled on accept
//   x1, y1, z1             input projective coordinates (W bits)
//   out_valid / out_ready  output handshake; result held until accepted
//   x2, y2, z2             doubled point (W bits, reduced mod P)
//   out_err                input out of range (range-check builds only)
module point_double_seq #(
    parameter int unsigned  W       = 255,
    parameter logic [W-1:0] P       = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed,
    parameter int           CURVE_A = -1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] z1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x2,
    output logic [W-1:0] y2,
    output logic [W-1:0] z2,
    output logic         out_err
);

    localparam int unsigned W1    = W + 1;
    localparam int unsigned ACC_W = W + 2;
    localparam int unsigned CNT_W = $clog2(W + 1);
    localparam logic        NEG_A = (CURVE_A == -1);

    if (CURVE_A != 1 && CURVE_A != -1) begin : g_bad_curve_a
        $error("point_double_seq: CURVE_A must be +1 or -1");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        ALU  = 3'd3,
        DONE = 3'd4
    } state_e;

    // One interleaved multiplier iteration: 2*acc + (bit ? a : 0), then
    // bring the sum (< 3P) back into [0, P).
    function automatic logic [ACC_W-1:0] mul_step(input logic [ACC_W-1:0] acc,
                                                  input logic [W-1:0]     a,
                                                  input logic             b);
        logic [ACC_W-1:0] t;
        t = (acc << 1) + (b ? ACC_W'(a) : '0);
        if (t >= ACC_W'(P)) t = t - ACC_W'(P);
        if (t >= ACC_W'(P)) t = t - ACC_W'(P);
        return t;
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W1-1:0] s;
        s = W1'(a) + W1'(b);
        if (s >= W1'(P)) s = s - W1'(P);
        return s[W-1:0];
    endfunction

    // Wraps mod 2^W; the true result lies in [0, P) so the W-bit value is exact.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (a < b) r = a - b + P;
        else       r = a - b;
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [W-1:0]       ma_q, ma_d;       // multiplicand
    logic [W-1:0]       mb_q, mb_d;       // multiplier, shifted out MSB first
    logic [W-1:0]       rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
    logic [W-1:0]       c_q, c_d;         // C, later reused for X2
    logic [W-1:0]       d_q, d_d;         // D, later reused for Y2
    logic [W-1:0]       g_q, g_d;         // B - C - D
    logic [W-1:0]       f_q, f_d;
    logic [W-1:0]       j_q, j_d;
    logic [W-1:0]       emd_q, emd_d;     // E - D
    logic [W-1:0]       x2_q, x2_d, y2_q, y2_d, z2_q, z2_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       prod_c, sum_c, e_c, f_c, j_c;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
    logic               err_q, err_d;
    logic               out_err_q, out_err_d;
`endif

    assign prod_c = acc_q[W-1:0];

    // Next-state, datapath and output logic.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        rz_d        = rz_q;
        c_d         = c_q;
        d_d         = d_q;
        g_d         = g_q;
        f_d         = f_q;
        j_d         = j_q;
        emd_d       = emd_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        z2_d        = z2_q;
        sum_c       = '0;
        e_c         = '0;
        f_c         = '0;
        j_c         = '0;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
        err_d       = err_q;
        out_err_d   = out_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rx_d    = x1;
                    ry_d    = y1;
                    rz_d    = z1;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
                    err_d   = (x1 >= P) || (y1 >= P) || (z1 >= P);
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ma_d    = rx_q;
                mb_d    = rx_q;
                acc_d   = '0;
                cnt_d   = '0;
                step_d  = '0;
                state_d = MUL;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
                out_err_d = 1'b0;
                if (err_q) begin
                    x2_d      = '0;
                    y2_d      = '0;
                    z2_d      = '0;
                    out_err_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            MUL: begin
                acc_d = mul_step(acc_q, ma_q, mb_q[W-1]);
                mb_d  = mb_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) state_d = ALU;
            end
            ALU: begin
                // Consume the finished product and load the next one.
                acc_d   = '0;
                cnt_d   = '0;
                step_d  = step_q + 3'd1;
                state_d = MUL;
                case (step_q)
                    3'd0: begin
                        c_d  = prod_c;
                        ma_d = ry_q;
                        mb_d = ry_q;
                    end
                    3'd1: begin
                        d_d   = prod_c;
                        sum_c = mod_add(rx_q, ry_q);
                        ma_d  = sum_c;
                        mb_d  = sum_c;
                    end
                    3'd2: begin
                        g_d  = mod_sub(mod_sub(prod_c, c_q), d_q);
                        ma_d = rz_q;
                        mb_d = rz_q;
                    end
                    3'd3: begin
                        // prod_c is H = Z1^2 here.
                        e_c   = NEG_A ? mod_sub('0, c_q) : c_q;
                        f_c   = mod_add(e_c, d_q);
                        j_c   = mod_sub(f_c, mod_add(prod_c, prod_c));
                        f_d   = f_c;
                        j_d   = j_c;
                        emd_d = mod_sub(e_c, d_q);
                        ma_d  = g_q;
                        mb_d  = j_c;
                    end
                    3'd4: begin
                        c_d  = prod_c;
                        ma_d = f_q;
                        mb_d = emd_q;
                    end
                    3'd5: begin
                        d_d  = prod_c;
                        ma_d = f_q;
                        mb_d = j_q;
                    end
                    3'd6: begin
                        x2_d    = c_q;
                        y2_d    = d_q;
                        z2_d    = prod_c;
                        state_d = DONE;
                    end
                    default: state_d = IDLE;
                endcase
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            rz_q        <= '0;
            c_q         <= '0;
            d_q         <= '0;
            g_q         <= '0;
            f_q         <= '0;
            j_q         <= '0;
            emd_q       <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            z2_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
            err_q       <= 1'b0;
            out_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            rz_q        <= rz_d;
            c_q         <= c_d;
            d_q         <= d_d;
            g_q         <= g_d;
            f_q         <= f_d;
            j_q         <= j_d;
            emd_q       <= emd_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            z2_q        <= z2_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
            err_q       <= err_d;
            out_err_q   <= out_err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x2        = x2_q;
    assign y2        = y2_q;
    assign z2        = z2_q;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
    assign out_err   = out_err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_point_double_seq.sv
// Directed bench for point_double_seq: W=8/P=13 with a=-1 and a=+1, plus the
// default W=255 Ed25519 configuration checked against affine doubling.
module tb_point_double_seq;

    localparam logic [254:0] P255 = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [254:0] BX   = 255'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
    localparam logic [254:0] BY   = 255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic       rst;
    logic       in_valid8, out_ready8;
    logic [7:0] x1_8, y1_8, z1_8;
    logic       in_ready8, out_valid8, out_err8;
    logic [7:0] x2_8, y2_8, z2_8;
    logic       in_ready8p, out_valid8p, out_err8p;
    logic [7:0] x2_8p, y2_8p, z2_8p;

    logic         in_valid_w, out_ready_w;
    logic [254:0] x1_w, y1_w, z1_w;
    logic         in_ready_w, out_valid_w, out_err_w;
    logic [254:0] x2_w, y2_w, z2_w;

    point_double_seq #(.W(8), .P(8'd13), .CURVE_A(-1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .x1(x1_8), .y1(y1_8), .z1(z1_8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .x2(x2_8), .y2(y2_8), .z2(z2_8), .out_err(out_err8));

    point_double_seq #(.W(8), .P(8'd13), .CURVE_A(1)) dut8p (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8p),
        .x1(x1_8), .y1(y1_8), .z1(z1_8),
        .out_valid(out_valid8p), .out_ready(out_ready8),
        .x2(x2_8p), .y2(y2_8p), .z2(z2_8p), .out_err(out_err8p));

    point_double_seq dut255 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .x1(x1_w), .y1(y1_w), .z1(z1_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .x2(x2_w), .y2(y2_w), .z2(z2_w), .out_err(out_err_w));

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one point on the 8-bit engines; lat = spec cycle index (accept = 0)
    // in which out_valid is first seen.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                        output int lat);
        x1_8 = x; y1_8 = y; z1_8 = z;
        in_valid8 = 1'b1;
        chk("accept_ready8", in_ready8, 1'b1);
        tick;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 200) begin
            tick;
            lat++;
        end
        chk("timeout8", out_valid8, 1'b1);
    endtask

    // Affine-field helpers for the W=255 reference (independent of the RTL schedule).
    function automatic logic [254:0] fm(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] t;
        t = 510'(a) * 510'(b);
        t = t % 510'(P255);
        return t[254:0];
    endfunction
    function automatic logic [254:0] fa(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] s;
        s = (256'(a) + 256'(b)) % 256'(P255);
        return s[254:0];
    endfunction
    function automatic logic [254:0] fs(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] s;
        s = (256'(a) + 256'(P255) - 256'(b)) % 256'(P255);
        return s[254:0];
    endfunction

    int           lat;
    int           na, nr;
    int           acc_cyc [3];
    logic [7:0]   px [3], py [3], pz [3];
    logic [7:0]   ex [3], ey [3], ez [3];
    logic [7:0]   rx [3], ry [3], rz [3];
    logic         acc_now, hs_now;
    logic [254:0] xx, yy, axx, dx, nx, dy, ny;

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        x1_8 = '0; y1_8 = '0; z1_8 = '0;
        in_valid_w = 1'b0; out_ready_w = 1'b1;
        x1_w = '0; y1_w = '0; z1_w = '0;
        px[0] = 8'd1; py[0] = 8'd2;  pz[0] = 8'd1; ex[0] = 8'd4; ey[0] = 8'd11; ez[0] = 8'd3;
        px[1] = 8'd0; py[1] = 8'd1;  pz[1] = 8'd1; ex[1] = 8'd0; ey[1] = 8'd12; ez[1] = 8'd12;
        px[2] = 8'd3; py[2] = 8'd5;  pz[2] = 8'd2; ex[2] = 8'd6; ey[2] = 8'd2;  ez[2] = 8'd11;

        // Reset state.
        tick;
        tick;
        rst = 1'b0;
        chk("rst_in_ready", in_ready8, 1'b1);
        chk("rst_in_ready_p", in_ready8p, 1'b1);
        chk("rst_in_ready_w", in_ready_w, 1'b1);
        chk("rst_out_valid", out_valid8, 1'b0);
        chk("rst_out_valid_w", out_valid_w, 1'b0);
        chk("rst_x2", x2_8, 8'd0);
        chk("rst_y2", y2_8, 8'd0);
        chk("rst_z2", z2_8, 8'd0);
        chk("rst_err", out_err8, 1'b0);

        // (1,2,1): a=-1 -> (4,11,3), a=+1 -> (12,11,2).
        run8(8'd1, 8'd2, 8'd1, lat);
        chk("p1_latency", lat, 65);
        chk("p1_x2", x2_8, 8'd4);
        chk("p1_y2", y2_8, 8'd11);
        chk("p1_z2", z2_8, 8'd3);
        chk("p1_err", out_err8, 1'b0);
        chk("p1a_valid", out_valid8p, 1'b1);
        chk("p1a_x2", x2_8p, 8'd12);
        chk("p1a_y2", y2_8p, 8'd11);
        chk("p1a_z2", z2_8p, 8'd2);
        chk("p1a_err", out_err8p, 1'b0);
        tick;
        chk("p1_back_idle", in_ready8, 1'b1);
        chk("p1_valid_drop", out_valid8, 1'b0);

        // Identity (0,1,1) -> (0,12,12) under backpressure; busy in_valid ignored.
        out_ready8 = 1'b0;
        run8(8'd0, 8'd1, 8'd1, lat);
        chk("id_latency", lat, 65);
        x1_8 = 8'd5; y1_8 = 8'd5; z1_8 = 8'd5;
        in_valid8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("bp_in_ready", in_ready8, 1'b0);
            chk("bp_valid", out_valid8, 1'b1);
            chk("bp_x2", x2_8, 8'd0);
            chk("bp_y2", y2_8, 8'd12);
            chk("bp_z2", z2_8, 8'd12);
            tick;
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        tick;
        chk("bp_release_idle", in_ready8, 1'b1);
        chk("bp_release_valid", out_valid8, 1'b0);

        // Reset in cycle 30 of an operation, then a fresh point.
        x1_8 = 8'd1; y1_8 = 8'd2; z1_8 = 8'd1;
        in_valid8 = 1'b1;
        tick;
        in_valid8 = 1'b0;
        for (int i = 1; i < 30; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_in_ready", in_ready8, 1'b1);
        chk("abort_valid", out_valid8, 1'b0);
        chk("abort_x2", x2_8, 8'd0);
        chk("abort_y2", y2_8, 8'd0);
        chk("abort_z2", z2_8, 8'd0);
        run8(8'd3, 8'd5, 8'd2, lat);
        chk("p3_latency", lat, 65);
        chk("p3_x2", x2_8, 8'd6);
        chk("p3_y2", y2_8, 8'd2);
        chk("p3_z2", z2_8, 8'd11);
        tick;

        // Out-of-range input.
        run8(8'd13, 8'd2, 8'd1, lat);
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
        chk("rng_latency", lat, 2);
        chk("rng_err", out_err8, 1'b1);
        chk("rng_x2", x2_8, 8'd0);
        chk("rng_y2", y2_8, 8'd0);
        chk("rng_z2", z2_8, 8'd0);
`else
        chk("rng_latency", lat, 65);
        chk("rng_err", out_err8, 1'b0);
`endif
        tick;

        // Back-to-back, three points with in_valid and out_ready held high.
        na = 0; nr = 0;
        x1_8 = px[0]; y1_8 = py[0]; z1_8 = pz[0];
        in_valid8 = 1'b1;
        for (int k = 0; k < 400 && nr < 3; k++) begin
            acc_now = in_valid8 && in_ready8;
            hs_now  = out_valid8 && out_ready8;
            if (hs_now) begin
                rx[nr] = x2_8; ry[nr] = y2_8; rz[nr] = z2_8;
            end
            tick;
            if (hs_now) nr++;
            if (acc_now) begin
                acc_cyc[na] = cyc;
                na++;
                if (na < 3) begin
                    x1_8 = px[na]; y1_8 = py[na]; z1_8 = pz[na];
                end else begin
                    in_valid8 = 1'b0;
                end
            end
        end
        chk("b2b_accepts", na, 3);
        chk("b2b_results", nr, 3);
        if (na == 3) begin
            chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 66);
            chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 66);
        end
        for (int i = 0; i < nr; i++) begin
            chk("b2b_x2", rx[i], ex[i]);
            chk("b2b_y2", ry[i], ey[i]);
            chk("b2b_z2", rz[i], ez[i]);
        end

        // Ed25519 base point, Z = 1, on the default W=255 instance.
        x1_w = BX; y1_w = BY; z1_w = 255'd1;
        in_valid_w = 1'b1;
        chk("w_accept_ready", in_ready_w, 1'b1);
        tick;
        in_valid_w = 1'b0;
        lat = 1;
        while (!out_valid_w && lat < 3000) begin
            tick;
            lat++;
        end
        chk("w_timeout", out_valid_w, 1'b1);
        chk("w_latency", lat, 1794);
        chk("w_err", out_err_w, 1'b0);
        // Affine doubling: x3 = 2xy/(a x^2 + y^2), y3 = (y^2 - a x^2)/(2 - a x^2 - y^2).
        xx  = fm(BX, BX);
        yy  = fm(BY, BY);
        axx = fs(255'd0, xx);
        dx  = fa(axx, yy);
        nx  = fm(255'd2, fm(BX, BY));
        ny  = fs(yy, axx);
        dy  = fs(fs(255'd2, axx), yy);
        chk("w_x_affine", fm(x2_w, dx), fm(nx, z2_w));
        chk("w_y_affine", fm(y2_w, dy), fm(ny, z2_w));
        chk("w_z_nonzero", (z2_w != '0), 1'b1);
        chk("w_x_reduced", (x2_w < P255), 1'b1);
        chk("w_y_reduced", (y2_w < P255), 1'b1);
        chk("w_z_reduced", (z2_w < P255), 1'b1);
        tick;
        chk("w_back_idle", in_ready_w, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
